lfsr_range_rng: RTL
===================

Name: lfsr_range_rng

Overview:
- Parametrised pseudo-random number source: a Galois LFSR of configurable width and polynomial, plus a request/valid front end.
- Each request returns a uniformly distributed integer in [OFFSET, OFFSET+RANGE-1], using rejection sampling with a bounded retry count.
- Supports runtime seed loading and all-zero lockup protection.
- Sits beside game/control logic that needs dice-style random values on demand.

Parameters:
- WIDTH, 16, LFSR state width (>=4).
- TAPS, 16'hB400, Galois feedback mask; default gives a maximal-length 65535 period.
- SEED, 16'hACE1, reset state and substitute for any all-zero seed; must be nonzero.
- RANGE, 6, number of distinct output values (2..2^WIDTH-1).
- OFFSET, 1, value added to every accepted draw.
- OUT_W, 3, width of q; must hold OFFSET+RANGE-1.
- MAX_TRIES, 8, draw attempts before fallback (>=1).

Ports:
- clk, input, 1, clock; all state changes on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- seed_load, input, 1, synchronous seed load strobe.
- seed_in, input, WIDTH, seed value used with seed_load.
- step_en, input, 1, free-run advance of the LFSR while idle.
- req, input, 1, request one random value.
- busy, output, 1, high while a draw is in progress.
- valid, output, 1, one-cycle pulse when q is updated.
- q, output, OUT_W, last delivered value; held between draws.
- state_o, output, WIDTH, current LFSR state (debug/observe).

Behaviour:
- LFSR step:
  - next = (state >> 1) XOR (state[0] ? TAPS : 0).
  - If state is ever all-zero, next = SEED (lockup recovery).
- Reset (async, rst=1): state=SEED, FSM=IDLE, busy=0, valid=0, q=OFFSET truncated to OUT_W, try counter=0.
- Derived constant: K = clog2(RANGE).
- Candidate c = next[K-1:0], compared unsigned against RANGE.
- FSM IDLE:
  - State advances one step per cycle when step_en=1, otherwise holds.
  - req=1 moves the FSM to DRAW; busy=1 from the next cycle; try counter cleared.
  - The LFSR also steps on that edge only if step_en=1.
- FSM DRAW:
  - LFSR steps every cycle; step_en is ignored.
  - If c < RANGE: q <= c+OFFSET, valid=1 next cycle, return to IDLE.
  - Otherwise, if tries < MAX_TRIES-1: stay in DRAW, increment tries.
  - Otherwise (final try): q <= (c-RANGE)+OFFSET, valid=1, return to IDLE. This is always in range because 2^K < 2*RANGE.
  - When RANGE is a power of two, no rejection ever occurs.
- Latency:
  - valid is asserted 2 cycles after the cycle in which req is sampled in IDLE (best case).
  - Worst case is MAX_TRIES+1 cycles.
  - valid is a single-cycle pulse; busy drops in the same cycle valid rises.
- req while busy is ignored; no queuing. req held high in IDLE starts back-to-back draws.
- seed_load (highest synchronous priority, any FSM state):
  - state <= seed_in, or SEED if seed_in==0.
  - Any DRAW is aborted: FSM=IDLE, no valid, q unchanged.
  - req in the same cycle is ignored.
- rst mid-DRAW: immediate return to reset values; the pending draw is lost.
- Arithmetic: c+OFFSET computed at OUT_W+1 bits and truncated to OUT_W. OFFSET/RANGE/OUT_W parameter consistency is the integrator's responsibility.

Test Plan:
1. Reset/step: rst pulse, step_en=1 for 3 cycles -> state_o: 0xACE1, 0xE270, 0x7138, 0x389C. q=1, valid=0, busy=0 after reset.
2. Accept-first draw: from reset, step_en=0, req for 1 cycle -> busy=1 for 1 cycle; valid pulse 2 cycles after req with q=1 (c=0 from 0xE270); state_o=0xE270.
3. Rejection then accept: seed_load with seed_in=0x000F, then req -> first candidate 7 from 0xB407 is rejected, second candidate 3 from 0xEE03 is accepted; valid 3 cycles after req, q=4.
4. Fallback: MAX_TRIES=1, seed 0x000F, req -> candidate 7 is rejected on the final try; q=(7-6)+1=2, valid 2 cycles after req.
5. Seed edge cases:
   - seed_load with seed_in=0 -> state_o=0xACE1.
   - seed_load asserted during DRAW -> no valid, busy=0 next cycle, q unchanged.
   - rst asserted mid-DRAW -> all outputs return to reset values.
6. Period/uniformity: step_en=1 for 65535 cycles from reset -> state_o returns to 0xACE1 exactly then and never reads 0. 6000 back-to-back draws -> every value 1..6 appears, q is never outside 1..6, and each valid is at most 9 cycles after its accepted req.

Source files
------------

// File: rtl/lfsr_range_rng.sv
// Galois LFSR with a request/valid front end that returns uniform values in
// [OFFSET, OFFSET+RANGE-1] by rejection sampling with a bounded number of tries.
module lfsr_range_rng #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS      = 16'hB400,
  parameter logic [WIDTH-1:0] SEED      = 16'hACE1,
  parameter int               RANGE     = 6,
  parameter int               OFFSET    = 1,
  parameter int               OUT_W     = 3,
  parameter int               MAX_TRIES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             step_en,
  input  logic             req,
  output logic             busy,
  output logic             valid,
  output logic [OUT_W-1:0] q,
  output logic [WIDTH-1:0] state_o
);

  localparam int K          = $clog2(RANGE);
  localparam int TRY_W      = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam int LAST_TRY_I = MAX_TRIES - 1;

  localparam logic [K:0]       RANGE_C  = RANGE[K:0];
  localparam logic [TRY_W-1:0] LAST_TRY = LAST_TRY_I[TRY_W-1:0];
  localparam logic [OUT_W-1:0] OFFSET_C = OFFSET[OUT_W-1:0];

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [OUT_W-1:0] q_q, q_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] step_nx;
  logic [K-1:0]     cand;
  logic [K-1:0]     cand_fb;
  logic             accept;

  // An all-zero state would lock the LFSR, so it is steered back to SEED.
  always_comb begin
    if (state_q == '0) begin
      step_nx = SEED;
    end else begin
      step_nx = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
    end
  end

  assign cand    = step_nx[K-1:0];
  assign accept  = ({1'b0, cand} < RANGE_C);
  assign cand_fb = cand - RANGE_C[K-1:0];

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    tries_d = tries_q;
    q_d     = q_q;
    valid_d = 1'b0;
    if (seed_load) begin
      state_d = (seed_in == '0) ? SEED : seed_in;
      fsm_d   = IDLE;
      tries_d = '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (step_en) state_d = step_nx;
          if (req) begin
            fsm_d   = DRAW;
            tries_d = '0;
          end
        end
        DRAW: begin
          state_d = step_nx;
          if (accept) begin
            q_d     = OUT_W'(cand) + OFFSET_C;
            valid_d = 1'b1;
            fsm_d   = IDLE;
          end else if (tries_q != LAST_TRY) begin
            tries_d = tries_q + TRY_W'(1);
          end else begin
            // 2^K < 2*RANGE, so subtracting RANGE once always lands in range.
            q_d     = OUT_W'(cand_fb) + OFFSET_C;
            valid_d = 1'b1;
            fsm_d   = IDLE;
          end
        end
        default: fsm_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= SEED;
      tries_q <= '0;
      q_q     <= OFFSET_C;
      valid_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      tries_q <= tries_d;
      q_q     <= q_d;
      valid_q <= valid_d;
    end
  end

  assign busy    = (fsm_q == DRAW);
  assign valid   = valid_q;
  assign q       = q_q;
  assign state_o = state_q;

endmodule
